fxp_ieee_encoder: RTL

FXP_IEEE_ENCODER -- requirements
Module: fxp_ieee_encoder

---
 rtl/fxp_ieee_pkg.sv | 30 +++
 rtl/fxp_ieee_encoder_lzc.sv | 26 ++
 rtl/fxp_ieee_encoder.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/fxp_ieee_pkg.sv
// Shared types and format constants for the fixed-point to IEEE-754 encoder.
`default_nettype none

package fxp_ieee_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic FMT_SP    = 1'b0;
  localparam logic FMT_DP    = 1'b1;
  localparam logic RND_RNE   = 1'b0;
  localparam logic RND_TRUNC = 1'b1;

  // Significant bits include the hidden leading one.
  localparam int SP_SIG  = 24;
  localparam int DP_SIG  = 53;
  localparam int SP_FRAC = 23;
  localparam int DP_FRAC = 52;
  localparam int SP_EXP  = 8;
  localparam int DP_EXP  = 11;
  localparam int SP_BIAS = 127;
  localparam int DP_BIAS = 1023;

endpackage

`default_nettype wire

// File: rtl/fxp_ieee_encoder_lzc.sv
// Leading-one detector: index of the most significant set bit plus an all-zero flag.
`default_nettype none

module lzc #(
  parameter int WIDTH = 37,
  localparam int PW   = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] value,
  output logic [PW-1:0]    pos,
  output logic             zero
);

  always_comb begin
    pos  = '0;
    zero = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      if (value[i]) begin
        pos  = PW'(i);
        zero = 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/fxp_ieee_encoder.sv
// Converts a signed fixed-point operand to IEEE-754 single or double precision
// through a four-state IDLE/NORM/ROUND/DONE sequence with valid/ack handshake.
`default_nettype none

module fxp_ieee_encoder
  import fxp_ieee_pkg::*;
#(
  parameter int INT_W  = 12,
  parameter int FRAC_W = 24
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [INT_W+FRAC_W-1:0] fp,
  input  logic                    fmt,
  input  logic                    rnd,
  output logic                    ready,
  output logic [63:0]             ieee,
  output logic                    valid,
  input  logic                    ack,
  output logic                    inexact,
  output logic [1:0]              state
);

  localparam int W     = INT_W + FRAC_W;
  localparam int MW    = W + 1;
  localparam int PW    = $clog2(MW);
  localparam int EXT_W = 128;

  state_t cur_state, nxt_state;

  logic [W-1:0]         fp_q;
  logic                 fmt_q, rnd_q, sign_q, zero_q;
  logic [MW-1:0]        norm_q;
  logic signed [10:0]   exp_q;
  logic [63:0]          ieee_q;
  logic                 inexact_q;

  always_ff @(posedge clk) begin
    if (rst) cur_state <= IDLE;
    else     cur_state <= nxt_state;
  end

  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      IDLE:    if (enable) nxt_state = NORM;
      NORM:    nxt_state = ROUND;
      ROUND:   nxt_state = DONE;
      DONE:    if (ack) nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase
  end

  assign ready   = (cur_state == IDLE);
  assign valid   = (cur_state == DONE);
  assign state   = cur_state;
  assign ieee    = ieee_q;
  assign inexact = inexact_q;

  // One extra bit so the most negative operand has an exact magnitude.
  logic [MW-1:0] fp_ext, mag;
  logic [PW-1:0] lead, shamt;
  logic          all_zero;

  assign fp_ext = {fp_q[W-1], fp_q};
  assign mag    = fp_q[W-1] ? -fp_ext : fp_ext;
  assign shamt  = PW'(MW - 1) - lead;

  lzc #(.WIDTH(MW)) u_lzc (
    .value (mag),
    .pos   (lead),
    .zero  (all_zero)
  );

  // Left-justified magnitude padded so both formats see guard/sticky bits.
  logic [EXT_W-1:0]     ext;
  logic [SP_SIG-1:0]    sp_keep;
  logic [DP_SIG-1:0]    dp_keep;
  logic                 sp_g, sp_s, sp_inc, dp_g, dp_s, dp_inc;
  logic [SP_SIG:0]      sp_sum;
  logic [DP_SIG:0]      dp_sum;
  logic [SP_FRAC-1:0]   sp_frac;
  logic [DP_FRAC-1:0]   dp_frac;
  logic [SP_EXP-1:0]    sp_bexp;
  logic [DP_EXP-1:0]    dp_bexp;
  logic [63:0]          res;
  logic                 res_inexact;

  assign ext     = {norm_q, {(EXT_W-MW){1'b0}}};
  assign sp_keep = ext[EXT_W-1 -: SP_SIG];
  assign sp_g    = ext[EXT_W-1-SP_SIG];
  assign sp_s    = |ext[EXT_W-2-SP_SIG:0];
  assign dp_keep = ext[EXT_W-1 -: DP_SIG];
  assign dp_g    = ext[EXT_W-1-DP_SIG];
  assign dp_s    = |ext[EXT_W-2-DP_SIG:0];

  assign sp_inc  = (rnd_q == RND_RNE) && sp_g && (sp_s || sp_keep[0]);
  assign dp_inc  = (rnd_q == RND_RNE) && dp_g && (dp_s || dp_keep[0]);
  assign sp_sum  = {1'b0, sp_keep} + (SP_SIG+1)'(sp_inc);
  assign dp_sum  = {1'b0, dp_keep} + (DP_SIG+1)'(dp_inc);

  // A carry-out leaves 1.000..0 x 2, so the fraction shifts right by one.
  assign sp_frac = sp_sum[SP_SIG] ? sp_sum[SP_SIG-1:1] : sp_sum[SP_FRAC-1:0];
  assign dp_frac = dp_sum[DP_SIG] ? dp_sum[DP_SIG-1:1] : dp_sum[DP_FRAC-1:0];
  assign sp_bexp = exp_q[SP_EXP-1:0] + SP_EXP'(sp_sum[SP_SIG]) + SP_EXP'(SP_BIAS);
  assign dp_bexp = exp_q + DP_EXP'(dp_sum[DP_SIG]) + DP_EXP'(DP_BIAS);

  always_comb begin
    res         = '0;
    res_inexact = 1'b0;
    if (!zero_q) begin
      if (fmt_q == FMT_DP) begin
        res         = {sign_q, dp_bexp, dp_frac};
        res_inexact = dp_g | dp_s;
      end else begin
        res         = {32'd0, sign_q, sp_bexp, sp_frac};
        res_inexact = sp_g | sp_s;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fp_q      <= '0;
      fmt_q     <= 1'b0;
      rnd_q     <= 1'b0;
      sign_q    <= 1'b0;
      zero_q    <= 1'b1;
      norm_q    <= '0;
      exp_q     <= '0;
      ieee_q    <= '0;
      inexact_q <= 1'b0;
    end else begin
      case (cur_state)
        IDLE: if (enable) begin
          fp_q  <= fp;
          fmt_q <= fmt;
          rnd_q <= rnd;
        end
        NORM: begin
          sign_q <= fp_q[W-1];
          zero_q <= all_zero;
          norm_q <= mag << shamt;
          exp_q  <= 11'(lead) - 11'(FRAC_W);
        end
        ROUND: begin
          ieee_q    <= res;
          inexact_q <= res_inexact;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire
